// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared vending types, default price/coin constants and helpers
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_READY = 2'd2
  } vend_state_e;

  localparam int DEF_PRICE         = 20;
  localparam int DEF_COIN_A        = 1;
  localparam int DEF_COIN_B        = 5;
  localparam int DEF_COIN_C        = 10;
  localparam int DEF_CREDIT_W      = 5;
  localparam int DEF_TICK_DIV      = 50_000_000;
  localparam int DEF_TIMEOUT_TICKS = 30;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/vend_tick_gen.sv
// rtl/vend_tick_gen.sv - divides clk into a one-cycle tick every TICK_DIV cycles
module vend_tick_gen import vend_pkg::*; #(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/vend_credit_ctrl.sv
// rtl/vend_credit_ctrl.sv - coin credit accumulator with vend, cancel refund and idle auto-refund
module vend_credit_ctrl import vend_pkg::*; #(
  parameter int PRICE         = DEF_PRICE,
  parameter int COIN_A        = DEF_COIN_A,
  parameter int COIN_B        = DEF_COIN_B,
  parameter int COIN_C        = DEF_COIN_C,
  parameter int CREDIT_W      = DEF_CREDIT_W,
  parameter int TICK_DIV      = DEF_TICK_DIV,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_a,
  input  logic                coin_b,
  input  logic                coin_c,
  input  logic                stop,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                ready,
  output logic                dispense,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change,
  output logic                coin_reject
);

  if (PRICE < 1 || TIMEOUT_TICKS < 1 ||
      (PRICE - 1 + max3(COIN_A, COIN_B, COIN_C)) >= (2 ** CREDIT_W)) begin : g_param_check
    $error("vend_credit_ctrl: PRICE/COIN/CREDIT_W/TIMEOUT_TICKS parameters inconsistent");
  end

  localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);

  function automatic vend_state_e state_of(input logic [CREDIT_W-1:0] c);
    if (c == '0)         return ST_IDLE;
    else if (c < PRICE_C) return ST_ACCUM;
    else                  return ST_READY;
  endfunction

  vend_state_e         state_q;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                dispense_q, dispense_d;
  logic                change_valid_q, change_valid_d;
  logic                coin_reject_q, coin_reject_d;
  logic                any_coin, activity, tick;
  logic [CREDIT_W-1:0] coin_value;

  assign any_coin = coin_a | coin_b | coin_c;
  assign activity = any_coin | stop | cancel;

  // Divider restarts on activity so the timeout spans whole ticks from the last input.
  vend_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (activity || credit_q == '0),
    .tick  (tick)
  );

  always_comb begin
    if (coin_a)      coin_value = CREDIT_W'(COIN_A);
    else if (coin_b) coin_value = CREDIT_W'(COIN_B);
    else             coin_value = CREDIT_W'(COIN_C);
  end

  always_comb begin
    credit_d       = credit_q;
    change_d       = '0;
    change_valid_d = 1'b0;
    dispense_d     = 1'b0;
    coin_reject_d  = 1'b0;
    idle_d         = idle_q;

    if (activity || credit_q == '0) begin
      idle_d = '0;
    end else if (tick) begin
      idle_d = idle_q + 1'b1;
    end

    if (cancel && credit_q != '0) begin
      change_valid_d = 1'b1;
      change_d       = credit_q;
      credit_d       = '0;
      coin_reject_d  = any_coin;
    end else if (stop && state_q == ST_READY) begin
      dispense_d    = 1'b1;
      credit_d      = credit_q - PRICE_C;
      coin_reject_d = any_coin;
    end else if (any_coin) begin
      if (state_q == ST_READY) begin
        coin_reject_d = 1'b1;
      end else begin
        credit_d      = credit_q + coin_value;
        coin_reject_d = (coin_a & (coin_b | coin_c)) | (coin_b & coin_c);
      end
    end else if (tick && credit_q != '0 && idle_q == IDLE_LAST) begin
      change_valid_d = 1'b1;
      change_d       = credit_q;
      credit_d       = '0;
      idle_d         = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      change_q       <= '0;
      idle_q         <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      state_q        <= state_of(credit_d);
      credit_q       <= credit_d;
      change_q       <= change_d;
      idle_q         <= idle_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign credit       = credit_q;
  assign ready        = (state_q == ST_READY);
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign change       = change_q;
  assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// tb/tb_vend_credit_ctrl.sv - scoreboard bench for vend_credit_ctrl with directed vectors
module tb_vend_credit_ctrl;

  localparam int CW = 5;
  localparam int TD = 4;
  localparam int TT = 3;

  localparam int K_CHG = 0;
  localparam int K_DSP = 1;
  localparam int K_REJ = 2;

  typedef struct {
    int kind;
    int value;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          coin_a = 1'b0, coin_b = 1'b0, coin_c = 1'b0;
  logic          stop = 1'b0, cancel = 1'b0;
  logic [CW-1:0] credit, change;
  logic          ready, dispense, change_valid, coin_reject;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  vend_credit_ctrl #(
    .PRICE(20), .COIN_A(1), .COIN_B(5), .COIN_C(10),
    .CREDIT_W(CW), .TICK_DIV(TD), .TIMEOUT_TICKS(TT)
  ) dut (
    .clk(clk), .reset(reset),
    .coin_a(coin_a), .coin_b(coin_b), .coin_c(coin_c),
    .stop(stop), .cancel(cancel),
    .credit(credit), .ready(ready), .dispense(dispense),
    .change_valid(change_valid), .change(change), .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  task automatic expect_pulse(input int kind, input int value);
    exp_t e;
    e.kind  = kind;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string name, input int kind, input int value);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected pulse value=%0d, none expected", name, value);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.value != value) begin
        errors++;
        $display("FAIL %s: got kind=%0d value=%0d, expected kind=%0d value=%0d",
                 name, kind, value, e.kind, e.value);
      end
    end
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (change_valid) pop_check("change", K_CHG, int'(change));
      else if (change != '0) begin
        checks++;
        errors++;
        $display("FAIL change_idle: change=%0d while change_valid low, expected 0", change);
      end
      if (dispense)    pop_check("dispense", K_DSP, 0);
      if (coin_reject) pop_check("coin_reject", K_REJ, 0);
    end
  end

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_credit(input string name, input int exp_credit, input int exp_ready);
    check_val({name, "_credit"}, int'(credit), exp_credit);
    check_val({name, "_ready"}, int'(ready), exp_ready);
  endtask

  task automatic cyc(input logic a, input logic b, input logic c, input logic s, input logic x);
    @(negedge clk);
    coin_a = a; coin_b = b; coin_c = c; stop = s; cancel = x;
    @(posedge clk);
    #1;
    coin_a = 0; coin_b = 0; coin_c = 0; stop = 0; cancel = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_credit("reset", 0, 0);
    check_val("reset_outputs", int'({dispense, change_valid, coin_reject}), 0);
    check_val("reset_change", int'(change), 0);
    @(negedge clk);
    reset = 0;

    // coin_c twice reaches price, stop vends everything
    cyc(0, 0, 1, 0, 0); check_credit("c1", 10, 0);
    cyc(0, 0, 1, 0, 0); check_credit("c2", 20, 1);
    expect_pulse(K_DSP, 0);
    cyc(0, 0, 0, 1, 0); check_credit("vend20", 0, 0);

    // build 19, overshoot to 29, vend leaves 9
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
    check_credit("build19", 19, 0);
    cyc(0, 0, 1, 0, 0); check_credit("over29", 29, 1);
    expect_pulse(K_DSP, 0);
    cyc(0, 0, 0, 1, 0); check_credit("vend29", 9, 0);
    cyc(0, 0, 0, 1, 0); check_credit("stop_accum", 9, 0);
    expect_pulse(K_CHG, 9);
    cyc(0, 0, 0, 0, 1); check_credit("cancel9", 0, 0);

    // coin in READY is rejected
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    expect_pulse(K_REJ, 0);
    cyc(0, 1, 0, 0, 0); check_credit("rej_ready", 20, 1);
    expect_pulse(K_DSP, 0);
    expect_pulse(K_REJ, 0);
    cyc(1, 0, 0, 1, 0); check_credit("stop_coin", 0, 0);

    // simultaneous coins: highest priority credited
    expect_pulse(K_REJ, 0);
    cyc(1, 1, 1, 0, 0); check_credit("abc", 1, 0);
    expect_pulse(K_REJ, 0);
    cyc(0, 1, 1, 0, 0); check_credit("bc", 6, 0);
    cyc(0, 0, 1, 0, 0); check_credit("c_only", 16, 0);
    expect_pulse(K_CHG, 16);
    expect_pulse(K_REJ, 0);
    cyc(1, 0, 0, 0, 1); check_credit("cancel_coin", 0, 0);
    cyc(0, 0, 0, 0, 1); check_credit("cancel_zero", 0, 0);

    // idle timeout refunds exactly TT*TD cycles after the last coin
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check_credit("build7", 7, 0);
    repeat (TT * TD - 1) @(posedge clk);
    #1;
    check_credit("pre_timeout", 7, 0);
    expect_pulse(K_CHG, 7);
    @(posedge clk);
    #1;
    check_credit("timeout", 0, 0);

    // cancel beats stop; reset discards credit without refund
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check_credit("build12", 12, 0);
    expect_pulse(K_CHG, 12);
    cyc(0, 0, 0, 1, 1); check_credit("cancel_stop", 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1; coin_c = 1; cancel = 1;
    @(posedge clk);
    #1;
    reset = 0; coin_c = 0; cancel = 0;
    check_credit("reset_mid", 0, 0);

    repeat (4) @(posedge clk);
    #1;
    check_val("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
